// File: rtl/control_step_generator_pkg.sv
// control_step_generator_pkg
//   Shared definitions for the control-step generator: state encoding,
//   step count / index width, and the LastStep clamp helper.
package control_step_generator_pkg;

    localparam int STEP_COUNT = 7;
    localparam int STEP_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SINGLE = 2'd2,
        HALTED = 2'd3
    } state_e;

    typedef logic [STEP_IDX_W-1:0] step_idx_t;
    typedef logic [STEP_COUNT-1:0] step_vec_t;

    // Out-of-range last-step requests collapse onto the highest real step.
    function automatic step_idx_t clamp_last(input step_idx_t value, input step_idx_t max_idx);
        return (value > max_idx) ? max_idx : value;
    endfunction

endpackage

// File: rtl/control_step_generator_if.sv
// control_step_generator_if
//   Control/status bundle between the CPU sequencing logic (master) and the
//   step generator (slave).
//   master -> slave : clock_enable, run, step_req, halt, clear_steps, last_step
//   slave -> master : steps, step_index, busy, instr_done, halted
interface control_step_generator_if;
    import control_step_generator_pkg::*;

    logic      clock_enable;
    logic      run;
    logic      step_req;
    logic      halt;
    logic      clear_steps;
    step_idx_t last_step;

    step_vec_t steps;
    step_idx_t step_index;
    logic      busy;
    logic      instr_done;
    logic      halted;

    modport master (
        output clock_enable, run, step_req, halt, clear_steps, last_step,
        input  steps, step_index, busy, instr_done, halted
    );

    modport slave (
        input  clock_enable, run, step_req, halt, clear_steps, last_step,
        output steps, step_index, busy, instr_done, halted
    );

endinterface

// File: rtl/control_step_generator_step_onehot_encoder.sv
// step_onehot_encoder
//   Combinational: turns a step index plus an active flag into the 7-line
//   one-hot vector, then applies the bubble (invert) mask.
//   index  in  current step index
//   active in  0 forces the raw vector to all-zero (all lines inactive)
//   steps  out raw one-hot XOR BUBBLES_MASK
module step_onehot_encoder
    import control_step_generator_pkg::*;
#(
    parameter step_vec_t BUBBLES_MASK = '0
) (
    input  step_idx_t index,
    input  logic      active,
    output step_vec_t steps
);

    step_vec_t raw;

    always_comb begin
        for (int i = 0; i < STEP_COUNT; i++) begin
            raw[i] = active && (index == step_idx_t'(i));
        end
        steps = raw ^ BUBBLES_MASK;
    end

endmodule

// File: rtl/control_step_generator.sv
// control_step_generator
//   One-hot timing-state generator (T0..T6) for the soft CPU control unit.
//   Steps continuously in RUN, one step per request in SINGLE, can be frozen
//   (HALTED) or cut short (clear_steps). Every output is registered.
//   global_clock in  rising-edge clock
//   reset_n      in  synchronous active-low reset, overrides clock_enable
//   bus          slave side of control_step_generator_if
module control_step_generator
    import control_step_generator_pkg::*;
#(
    parameter step_vec_t BUBBLES_MASK = '0,
    parameter int        NR_OF_STEPS  = 7
) (
    input logic                      global_clock,
    input logic                      reset_n,
    control_step_generator_if.slave  bus
);

    localparam step_idx_t MAX_IDX = step_idx_t'(NR_OF_STEPS - 1);

    state_e    state_q, state_d;
    state_e    resume_q, resume_d;   // mode to return to when HALTED releases
    step_idx_t idx_q, idx_d;
    step_idx_t last_q, last_d;
    step_vec_t steps_q, steps_d;
    logic      done_q, done_d;
    logic      busy_q, halted_q;
    logic      advance;
    step_idx_t last_in;

    assign last_in = clamp_last(bus.last_step, MAX_IDX);

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        idx_d    = idx_q;
        last_d   = last_q;
        done_d   = 1'b0;
        advance  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Halt has no meaning here; Run wins over a single-step request.
                if (bus.run || bus.step_req) begin
                    state_d = bus.run ? RUN : SINGLE;
                    idx_d   = '0;
                    last_d  = last_in;
                end
            end
            RUN, SINGLE: begin
                if (bus.halt) begin
                    resume_d = state_q;
                    state_d  = HALTED;
                end else if (bus.clear_steps) begin
                    idx_d  = '0;
                    last_d = last_in;
                    done_d = 1'b1;
                end else if (state_q == RUN) begin
                    advance = 1'b1;
                end else if (bus.run) begin
                    state_d = RUN;         // mode switch only, no step this edge
                end else if (bus.step_req) begin
                    advance = 1'b1;
                end
            end
            HALTED: begin
                if (!bus.halt) state_d = resume_q;
            end
        endcase

        if (advance) begin
            if (idx_q == last_q) begin
                idx_d  = '0;
                done_d = 1'b1;
                last_d = last_in;
                // Dropping Run only takes effect at an instruction boundary.
                if (state_q == RUN && !bus.run) state_d = IDLE;
            end else begin
                idx_d = idx_q + step_idx_t'(1);
            end
        end
    end

    step_onehot_encoder #(.BUBBLES_MASK(BUBBLES_MASK)) u_encoder (
        .index  (idx_d),
        .active (state_d != IDLE),
        .steps  (steps_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the reset is synchronous, checked inside the
    // clocked block, and takes precedence over clock_enable.
    always_ff @(posedge global_clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            resume_q <= IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            steps_q  <= BUBBLES_MASK;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else if (bus.clock_enable) begin
            state_q  <= state_d;
            resume_q <= resume_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            steps_q  <= steps_d;
            done_q   <= done_d;
            busy_q   <= (state_d != IDLE);
            halted_q <= (state_d == HALTED);
        end else begin
            // Everything freezes except the completion pulse, which must not
            // stretch across a stalled cycle.
            done_q <= 1'b0;
        end
    end

    assign bus.steps      = steps_q;
    assign bus.step_index = idx_q;
    assign bus.busy       = busy_q;
    assign bus.instr_done = done_q;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_control_step_generator.sv
module tb_control_step_generator;

    localparam logic [6:0] MASK = 7'b0000101;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    control_step_generator_if bus();

    control_step_generator #(.BUBBLES_MASK(MASK), .NR_OF_STEPS(7)) dut (
        .global_clock (clk),
        .reset_n      (reset_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks "is an instruction in flight", "continuous or single", "frozen",
    // the position within the instruction and its length.
    bit m_active, m_cont, m_frozen, m_done;
    int m_pos, m_last;

    function automatic int lim(input int v);
        return (v > 6) ? 6 : v;
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            m_active = 0; m_cont = 0; m_frozen = 0; m_done = 0; m_pos = 0; m_last = 0;
            return;
        end
        m_done = 0;
        if (!bus.clock_enable) return;
        if (!m_active) begin
            if (bus.run || bus.step_req) begin
                m_active = 1; m_cont = bus.run; m_pos = 0; m_last = lim(int'(bus.last_step));
            end
        end else if (m_frozen) begin
            if (!bus.halt) m_frozen = 0;
        end else if (bus.halt) begin
            m_frozen = 1;
        end else if (bus.clear_steps) begin
            m_pos = 0; m_last = lim(int'(bus.last_step)); m_done = 1;
        end else if (!m_cont && bus.run) begin
            m_cont = 1;
        end else if (m_cont || bus.step_req) begin
            if (m_pos == m_last) begin
                m_pos = 0; m_done = 1; m_last = lim(int'(bus.last_step));
                if (m_cont && !bus.run) m_active = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_model();
        logic [6:0] exp_steps;
        exp_steps = (m_active ? 7'(1 << m_pos) : 7'd0) ^ MASK;
        check("model_steps",  32'(bus.steps),      32'(exp_steps));
        check("model_index",  32'(bus.step_index), 32'(m_pos));
        check("model_busy",   32'(bus.busy),       32'(m_active));
        check("model_done",   32'(bus.instr_done), 32'(m_done));
        check("model_halted", 32'(bus.halted),     32'(m_frozen));
    endtask

    // One rising edge; outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic set_in(input bit ce, input bit run, input bit sreq, input bit halt,
                          input bit clr, input int last);
        bus.clock_enable = ce;
        bus.run          = run;
        bus.step_req     = sreq;
        bus.halt         = halt;
        bus.clear_steps  = clr;
        bus.last_step    = 3'(last);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        check("reset_steps", 32'(bus.steps), 32'(MASK));
        check("reset_index", 32'(bus.step_index), 32'd0);
        check("reset_busy",  32'(bus.busy), 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic expect_idx(input string name, input int idx, input bit done);
        check({name, "_idx"},  32'(bus.step_index), 32'(idx));
        check({name, "_done"}, 32'(bus.instr_done), 32'(done));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit ce, run, sreq, halt, clr;
        int last;
        int e_idx;
        bit e_done, e_busy, e_halt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit ce, input bit run, input bit sreq, input bit halt,
                                input bit clr, input int last, input int e_idx,
                                input bit e_done, input bit e_busy, input bit e_halt);
        vec_t v;
        v.ce = ce; v.run = run; v.sreq = sreq; v.halt = halt; v.clr = clr; v.last = last;
        v.e_idx = e_idx; v.e_done = e_done; v.e_busy = e_busy; v.e_halt = e_halt;
        return v;
    endfunction

    initial begin
        set_in(1, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        do_reset();

        // RUN, LastStep=3: 0,1,2,3,0(done),1 then drop Run -> finish and idle
        vecs.push_back(mk(1,1,0,0,0,3, 0,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,3, 1,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,3, 2,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,3, 3,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,3, 0,1,1,0));
        vecs.push_back(mk(1,1,0,0,0,3, 1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,3, 2,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,3, 3,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,3, 0,1,0,0));
        // RUN, LastStep=6, Run dropped at index 2 -> 3..6, wrap, IDLE
        vecs.push_back(mk(1,1,0,0,0,6, 0,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,6, 1,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,6, 2,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,6, 3,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,6, 4,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,6, 5,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,6, 6,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,6, 0,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,6, 0,0,0,0));
        // SINGLE, LastStep=2; lost request under ClockEnable=0
        vecs.push_back(mk(1,0,1,0,0,2, 0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,2, 0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,2, 0,0,1,0));
        vecs.push_back(mk(1,0,1,0,0,2, 1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,2, 1,0,1,0));
        vecs.push_back(mk(0,0,1,0,0,2, 1,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,2, 1,0,1,0));
        vecs.push_back(mk(1,0,1,1,0,2, 1,0,1,1));   // request with Halt: ignored
        vecs.push_back(mk(1,0,0,0,0,2, 1,0,1,0));
        vecs.push_back(mk(1,0,1,0,0,2, 2,0,1,0));
        vecs.push_back(mk(1,0,1,0,0,2, 0,1,1,0));
        vecs.push_back(mk(1,0,0,0,0,2, 0,0,1,0));
        // SINGLE -> RUN switch: no advance on the switching edge
        vecs.push_back(mk(1,1,0,0,0,2, 0,0,1,0));
        vecs.push_back(mk(1,1,1,0,0,2, 1,0,1,0));   // StepReq in RUN ignored

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].ce, vecs[i].run, vecs[i].sreq, vecs[i].halt, vecs[i].clr, vecs[i].last);
            tick();
            check($sformatf("vec%0d_idx", i),    32'(bus.step_index), 32'(vecs[i].e_idx));
            check($sformatf("vec%0d_done", i),   32'(bus.instr_done), 32'(vecs[i].e_done));
            check($sformatf("vec%0d_busy", i),   32'(bus.busy),       32'(vecs[i].e_busy));
            check($sformatf("vec%0d_halted", i), 32'(bus.halted),     32'(vecs[i].e_halt));
        end

        // Halt at index 4 for 10 cycles; index 5 on the second edge after release
        set_in(1, 0, 0, 0, 0, 0);
        do_reset();
        set_in(1, 1, 0, 0, 0, 6);
        for (int i = 0; i < 5; i++) tick();
        expect_idx("pre_halt", 4, 0);
        bus.halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halt_idx",    32'(bus.step_index), 32'd4);
            check("halt_flag",   32'(bus.halted), 32'd1);
            check("halt_steps",  32'(bus.steps), 32'(7'b0010000 ^ MASK));
        end
        bus.halt = 1'b0;
        tick();
        expect_idx("release1", 4, 0);
        check("release1_halted", 32'(bus.halted), 32'd0);
        tick();
        expect_idx("release2", 5, 0);

        // ClearSteps at index 3 while LastStep changes 5 -> 1
        set_in(1, 0, 0, 0, 0, 0);
        do_reset();
        set_in(1, 1, 0, 0, 0, 5);
        for (int i = 0; i < 4; i++) tick();
        expect_idx("pre_clear", 3, 0);
        set_in(1, 1, 0, 0, 1, 1);
        tick();
        expect_idx("clear", 0, 1);
        check("clear_busy", 32'(bus.busy), 32'd1);
        bus.clear_steps = 1'b0;
        tick(); expect_idx("clear_seq1", 1, 0);
        tick(); expect_idx("clear_seq2", 0, 1);
        tick(); expect_idx("clear_seq3", 1, 0);

        // LastStep=7 clamps to 6
        set_in(1, 0, 0, 0, 0, 0);
        do_reset();
        set_in(1, 1, 0, 0, 0, 7);
        for (int i = 0; i < 7; i++) tick();
        expect_idx("clamp_top", 6, 0);
        check("clamp_steps", 32'(bus.steps), 32'(7'b1000000 ^ MASK));
        tick();
        expect_idx("clamp_wrap", 0, 1);

        // LastStep=0: every advance completes; no pulse with ClockEnable=0
        set_in(1, 0, 0, 0, 0, 0);
        do_reset();
        set_in(1, 1, 0, 0, 0, 0);
        tick(); expect_idx("last0_entry", 0, 0);
        tick(); expect_idx("last0_a", 0, 1);
        tick(); expect_idx("last0_b", 0, 1);
        bus.clock_enable = 1'b0;
        tick(); expect_idx("last0_ce0", 0, 0);
        check("last0_ce0_busy", 32'(bus.busy), 32'd1);

        // Reset while HALTED with Run=1 and ClockEnable=0
        set_in(1, 1, 0, 0, 0, 4);
        tick(); tick();
        bus.halt = 1'b1;
        tick();
        check("pre_reset_halted", 32'(bus.halted), 32'd1);
        bus.clock_enable = 1'b0;
        reset_n = 1'b0;
        tick();
        check("hreset_steps",  32'(bus.steps), 32'(MASK));
        check("hreset_index",  32'(bus.step_index), 32'd0);
        check("hreset_busy",   32'(bus.busy), 32'd0);
        check("hreset_done",   32'(bus.instr_done), 32'd0);
        check("hreset_halted", 32'(bus.halted), 32'd0);
        reset_n = 1'b1;

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            reset_n          = ($urandom_range(0, 99) != 0);
            bus.clock_enable = ($urandom_range(0, 9) != 0);
            bus.run          = ($urandom_range(0, 3) != 0) ? bus.run : ~bus.run;
            bus.step_req     = ($urandom_range(0, 3) == 0);
            bus.halt         = ($urandom_range(0, 11) == 0) ? ~bus.halt : bus.halt;
            bus.clear_steps  = ($urandom_range(0, 19) == 0);
            bus.last_step    = 3'($urandom_range(0, 7));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_step_generator.md
# control_step_generator

Sequential timing-state generator for the prototype soft CPU: produces a 7-line one-hot control-step vector (T0..T6) that feeds the control unit's 7-input bubble-masked AND decode gates. Advances one step per enabled clock in run mode, or one step per request in single-step mode. Supports a per-instruction last step, early clear, and halt. An output invert mask matches the gates' bubble convention.

## Interface
- BubblesMask, 0: 7-bit output invert mask. Bit i set means Steps[i] is active-low.
- NrOfSteps, 7: fixed at 7; not to be overridden.
- GlobalClock  in  1  system clock, rising edge
- Reset_n  in  1  synchronous, active-low reset; overrides ClockEnable
- ClockEnable  in  1  global tick; when 0, all state is frozen
- Run  in  1  level; request continuous stepping
- StepReq  in  1  single-cycle pulse; advance one step in single-step mode
- Halt  in  1  level; freeze the current step
- ClearSteps  in  1  pulse; end the current instruction early and return to T0
- LastStep  in  3  index of the final step of this instruction (0..6)
- Steps  out  7  one-hot step vector, XOR BubblesMask
- StepIndex  out  3  current step index
- Busy  out  1  state is not IDLE
- InstrDone  out  1  one-cycle pulse on the cycle the final step completes
- Halted  out  1  state is HALTED

## Operation
- States: IDLE, RUN, SINGLE, HALTED. State, index, latched LastStep and all outputs are registered.
- Reset (Reset_n=0 at an edge):
  - state IDLE, index 0
  - Steps = BubblesMask, i.e. all lines inactive
  - StepIndex 0, Busy 0, InstrDone 0, Halted 0
- Input priority at every enabled edge: Reset_n > Halt > ClearSteps > Run/StepReq advance.
- IDLE:
  - raw step vector is all-zero
  - Run=1: go to RUN at index 0
  - otherwise StepReq=1: go to SINGLE at index 0
  - either entry latches LastStep
- RUN:
  - index advances by 1 each enabled edge
  - at index == latched last step: index wraps to 0, InstrDone=1 for that cycle, LastStep is re-latched
  - if Run=0 at that wrap: go to IDLE instead
  - Run deasserting mid-instruction does not stop stepping before the last step
- SINGLE:
  - index holds
  - each StepReq advances by 1, using the same wrap and InstrDone rules
  - Run=1 switches to RUN without advancing on that edge
- HALTED:
  - entered from RUN or SINGLE when Halt=1; index and Steps are frozen
  - Halt=0 returns to the prior mode (RUN or SINGLE), and the first advance occurs on the following edge
  - Halt=1 in IDLE has no effect
- ClearSteps in RUN or SINGLE:
  - index goes to 0 and LastStep is re-latched
  - InstrDone=1 (the instruction is terminated)
  - state is unchanged
- LastStep > 6 is clamped to 6. LastStep is sampled only when latched (entry, wrap, clear); changes mid-instruction are ignored.
- LastStep=0: every advance wraps, and InstrDone is high on every advancing edge.
- Raw vector: bit[index] = 1 in every state except IDLE. Steps = raw XOR BubblesMask.

## Timing
- All outputs change only on a GlobalClock rising edge.
- Run sampled high at edge k while IDLE: Steps[0] becomes active after edge k, Steps[1] after edge k+1.
- InstrDone is asserted in the same cycle that index returns to 0. It is never asserted when ClockEnable=0.
- StepReq with ClockEnable=0 is lost, not queued.
- StepReq coincident with Halt is ignored.
- StepReq in RUN is ignored.
- Reset mid-instruction: the next cycle shows the reset values regardless of Halt, Run or ClockEnable.
- No combinational path from any input to any output.

## Structure
- Shared package holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, SINGLE=2'd2, HALTED=2'd3
  - STEP_COUNT=7, STEP_IDX_W=3
- One sub-module, step_onehot_encoder: 3-bit index plus an active flag and the BubblesMask parameter in, 7-bit masked vector out. It is combinational and registered by the parent.

## Test plan
- Reset with BubblesMask=7'b0000101 → Steps=0000101, Busy=0, StepIndex=0. Then Run=1, LastStep=3 → StepIndex sequence 0,1,2,3,0,…; InstrDone high on each return to 0.
- RUN with LastStep=6; drop Run at index 2 → continues 3,4,5,6; InstrDone on wrap; then IDLE, Steps=BubblesMask.
- SINGLE with LastStep=2; StepReq pulses separated by 5 idle cycles → one advance per pulse; StepReq during ClockEnable=0 has no effect.
- RUN with Halt=1 at index 4 for 10 cycles → index stays 4 and Halted=1; release → index 5 on the second edge after release.
- ClearSteps at index 3 while LastStep changes 5→1 → index 0 and InstrDone=1, then sequence 0,1,0 using the new LastStep. LastStep=7 → behaves as 6.
- Reset_n=0 while in HALTED with Run=1 and ClockEnable=0 → reset values appear after the next edge.
